// File: rtl/i2c_pkg.sv
// i2c_pkg: shared encodings for the I2C transaction sequencer.
// Engine op codes, sequencer FSM states and the command-sequence step
// index, plus helpers that map a step to its engine op and successor.
package i2c_pkg;

  typedef enum logic [2:0] {
    OP_START  = 3'd0,
    OP_RSTART = 3'd1,
    OP_WRITE  = 3'd2,
    OP_READ   = 3'd3,
    OP_STOP   = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // One entry per engine command of a register access.
  typedef enum logic [2:0] {
    STEP_START,
    STEP_ADDR_W,
    STEP_REG,
    STEP_DATA,
    STEP_RSTART,
    STEP_ADDR_R,
    STEP_READ,
    STEP_STOP
  } step_e;

  // Engine op issued for a given step; every address/register/data byte is a WRITE.
  function automatic op_e step_op(step_e s);
    case (s)
      STEP_START:  return OP_START;
      STEP_RSTART: return OP_RSTART;
      STEP_READ:   return OP_READ;
      STEP_STOP:   return OP_STOP;
      default:     return OP_WRITE;
    endcase
  endfunction

  // Successor step: writes go REG -> DATA, reads go REG -> RSTART -> ADDR+R -> READ.
  function automatic step_e next_step(step_e s, logic rnw);
    case (s)
      STEP_START:  return STEP_ADDR_W;
      STEP_ADDR_W: return STEP_REG;
      STEP_REG:    return rnw ? STEP_RSTART : STEP_DATA;
      STEP_RSTART: return STEP_ADDR_R;
      STEP_ADDR_R: return STEP_READ;
      default:     return STEP_STOP;
    endcase
  endfunction

  // Steps whose response can carry a slave NACK.
  function automatic logic is_write_step(step_e s);
    return (s == STEP_ADDR_W) || (s == STEP_REG) || (s == STEP_DATA) || (s == STEP_ADDR_R);
  endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// i2c_rr_arbiter: round-robin pick among NUM_REQ request lines.
// Grants the first set request at or after the pointer (wrapping). The
// pointer moves to grant+1 when the parent signals that the grant was taken.
module i2c_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_50,
  input  logic               state_reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] ptr_q;
  int               idx;

  // Scan requesters starting at the pointer and take the first one set.
  always_comb begin
    // NOTE: every output gets a value before the loop so no path leaves one unassigned (no latch).
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  // Pointer moves past the requester that was just served.
  always_ff @(posedge clk_50 or negedge state_reset) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!state_reset) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: shares one byte-level I2C engine among NUM_REQ clients.
// Each granted request is expanded into START, ADDR+W, REG, DATA, STOP (write)
// or START, ADDR+W, REG, RSTART, ADDR+R, READ, STOP (read).
// Optional macro I2C_TXN_TIMEOUT_EN adds a per-step response timeout.
module i2c_txn_sequencer
  import i2c_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk_50,
  input  logic                 state_reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rnw,
  input  logic [7*NUM_REQ-1:0] req_dev,
  input  logic [8*NUM_REQ-1:0] req_reg,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 eng_cmd_valid,
  input  logic                 eng_cmd_ready,
  output logic [2:0]           eng_cmd_op,
  output logic [7:0]           eng_cmd_data,
  input  logic                 eng_rsp_valid,
  input  logic                 eng_rsp_nack,
  input  logic [7:0]           eng_rsp_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_params
    $error("i2c_txn_sequencer: NUM_REQ must be 2..8 and TIMEOUT_CYC 1..65535");
  end

  state_e               state_q, state_d;
  step_e                step_q, step_d;
  logic                 err_q, err_d;
  logic [7:0]           rdata_q, rdata_d;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 rnw_q;
  logic [6:0]           dev_q;
  logic [7:0]           reg_q, wdata_q;
  logic                 latch, step_adv, tmo_hit;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;

  i2c_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk_50      (clk_50),
    .state_reset (state_reset),
    .req         (req),
    .advance     (latch),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

`ifdef I2C_TXN_TIMEOUT_EN
  logic [15:0] tmo_q;

  // Response timer: counts while a step is in flight, restarts on every step change.
  always_ff @(posedge clk_50 or negedge state_reset) begin
    if (!state_reset) begin
      tmo_q <= '0;
    end else if ((state_q == ST_ISSUE || state_q == ST_WAIT) && !step_adv) begin
      tmo_q <= tmo_q + 16'd1;
    end else begin
      tmo_q <= '0;
    end
  end

  assign tmo_hit = (state_q == ST_ISSUE || state_q == ST_WAIT) &&
                   (tmo_q >= 16'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state logic: arbitration, command issue and response handling.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    latch    = 1'b0;
    step_adv = 1'b0;
    case (state_q)
      ST_IDLE: if (|req) state_d = ST_ARB;
      ST_ARB: begin
        if (arb_valid) begin
          latch   = 1'b1;
          step_d  = STEP_START;
          err_d   = 1'b0;
          rdata_d = 8'h00;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (eng_cmd_ready) begin
          state_d = ST_WAIT;
        end else if (tmo_hit) begin
          step_adv = 1'b1;
          err_d    = 1'b1;
          if (step_q == STEP_STOP) state_d = ST_DONE;
          else                     step_d  = STEP_STOP;
        end
      end
      ST_WAIT: begin
        if (eng_rsp_valid) begin
          step_adv = 1'b1;
          if (step_q == STEP_STOP) begin
            state_d = ST_DONE;
          end else if (is_write_step(step_q) && eng_rsp_nack) begin
            err_d   = 1'b1;
            step_d  = STEP_STOP;
            state_d = ST_ISSUE;
          end else begin
            if (step_q == STEP_READ) rdata_d = eng_rsp_data;
            step_d  = next_step(step_q, rnw_q);
            state_d = ST_ISSUE;
          end
        end else if (tmo_hit) begin
          step_adv = 1'b1;
          err_d    = 1'b1;
          if (step_q == STEP_STOP) begin
            state_d = ST_DONE;
          end else begin
            step_d  = STEP_STOP;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, step and result registers; request fields captured once at grant.
  always_ff @(posedge clk_50 or negedge state_reset) begin
    if (!state_reset) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_START;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      gnt_q   <= '0;
      rnw_q   <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (latch) begin
        gnt_q   <= arb_grant;
        rnw_q   <= req_rnw[arb_idx];
        dev_q   <= req_dev[7*arb_idx +: 7];
        reg_q   <= req_reg[8*arb_idx +: 8];
        wdata_q <= req_wdata[8*arb_idx +: 8];
      end
    end
  end

  // Outputs decoded from registered state so reset clears them at once.
  always_comb begin
    busy          = (state_q == ST_ARB) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    done          = (state_q == ST_DONE) ? gnt_q : '0;
    err           = (state_q == ST_DONE) && err_q;
    rdata         = (state_q == ST_DONE && !err_q) ? rdata_q : 8'h00;
    eng_cmd_valid = (state_q == ST_ISSUE);
    eng_cmd_op    = eng_cmd_valid ? step_op(step_q) : OP_START;
    eng_cmd_data  = 8'h00;
    if (eng_cmd_valid) begin
      case (step_q)
        STEP_ADDR_W: eng_cmd_data = {dev_q, 1'b0};
        STEP_ADDR_R: eng_cmd_data = {dev_q, 1'b1};
        STEP_REG:    eng_cmd_data = reg_q;
        STEP_DATA:   eng_cmd_data = wdata_q;
        STEP_READ:   eng_cmd_data = 8'h01;  // master NACKs the single byte read
        default:     eng_cmd_data = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed bench for i2c_txn_sequencer (NUM_REQ=4).
// A zero-wait engine model logs every accepted command and answers one
// cycle later. Build with +define+I2C_TXN_TIMEOUT_EN to add the timeout test.
module tb_i2c_txn_sequencer;

  localparam int N = 4;
  localparam logic [2:0] OP_START  = 3'd0;
  localparam logic [2:0] OP_RSTART = 3'd1;
  localparam logic [2:0] OP_WRITE  = 3'd2;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_STOP   = 3'd4;

  logic           clk_50 = 1'b0;
  logic           state_reset;
  logic [N-1:0]   req, req_rnw, done;
  logic [7*N-1:0] req_dev;
  logic [8*N-1:0] req_reg, req_wdata;
  logic           err, busy, eng_cmd_valid, eng_cmd_ready, eng_rsp_valid, eng_rsp_nack;
  logic [7:0]     rdata, eng_cmd_data, eng_rsp_data;
  logic [2:0]     eng_cmd_op;

  int checks = 0;
  int errors = 0;

  // Engine model state and command log.
  logic       silent, nack_en, pending;
  logic [7:0] nack_byte, read_byte;
  int         cyc = 0;
  logic [2:0] log_op[$];
  logic [7:0] log_data[$];
  int         log_cyc[$];

  // Values captured at a done pulse.
  logic [N-1:0] cap_done;
  logic         cap_err;
  logic [7:0]   cap_rdata;

  i2c_txn_sequencer #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
    .clk_50        (clk_50),
    .state_reset   (state_reset),
    .req           (req),
    .req_rnw       (req_rnw),
    .req_dev       (req_dev),
    .req_reg       (req_reg),
    .req_wdata     (req_wdata),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .busy          (busy),
    .eng_cmd_valid (eng_cmd_valid),
    .eng_cmd_ready (eng_cmd_ready),
    .eng_cmd_op    (eng_cmd_op),
    .eng_cmd_data  (eng_cmd_data),
    .eng_rsp_valid (eng_rsp_valid),
    .eng_rsp_nack  (eng_rsp_nack),
    .eng_rsp_data  (eng_rsp_data)
  );

  always #10 clk_50 = ~clk_50;

  // Engine model: log each handshake, respond on the following cycle.
  always @(negedge clk_50) begin
    cyc++;
    if (!state_reset) begin
      pending       = 1'b0;
      eng_rsp_valid = 1'b0;
    end else begin
      eng_rsp_valid = pending;
      pending       = 1'b0;
      if (eng_cmd_valid && eng_cmd_ready) begin
        log_op.push_back(eng_cmd_op);
        log_data.push_back(eng_cmd_data);
        log_cyc.push_back(cyc);
        if (!silent) begin
          pending      = 1'b1;
          eng_rsp_nack = nack_en && (eng_cmd_op == OP_WRITE) && (eng_cmd_data == nack_byte);
          eng_rsp_data = read_byte;
        end
      end
    end
  end

  task automatic clear_log();
    log_op.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic set_req(input int i, input logic rnw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd);
    req_rnw[i]          = rnw;
    req_dev[7*i +: 7]   = dev;
    req_reg[8*i +: 8]   = rg;
    req_wdata[8*i +: 8] = wd;
  endtask

  // Bounded wait for a done pulse; counts busy cycles seen before it.
  task automatic wait_done(input int max_cyc, output logic ok, output int busy_cyc);
    ok = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_50);
      if (|done) begin
        ok = 1'b1;
        cap_done = done;
        cap_err = err;
        cap_rdata = rdata;
        break;
      end
      if (busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    state_reset = 1'b0;
    repeat (2) @(negedge clk_50);
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (eng_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b expected 0", eng_cmd_valid); end
    checks++; if ({err, rdata} !== 9'h000) begin errors++; $display("FAIL reset_err_rdata: got %h expected 000", {err, rdata}); end
    state_reset = 1'b1;
    repeat (2) @(negedge clk_50);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write();
    logic ok;
    int bc0, bc;
    logic [2:0] eo[5] = '{OP_START, OP_WRITE, OP_WRITE, OP_WRITE, OP_STOP};
    logic [7:0] ed[5] = '{8'h00, 8'hD0, 8'h38, 8'hF0, 8'h00};
    clear_log();
    set_req(0, 1'b0, 7'h68, 8'h38, 8'hF0);
    req[0] = 1'b1;
    bc0 = 0;
    repeat (3) begin @(negedge clk_50); if (busy) bc0++; end
    // Fields are latched at grant; later input changes must not leak through.
    set_req(0, 1'b1, 7'h11, 8'h22, 8'h00);
    wait_done(100, ok, bc);
    req[0] = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL write_timeout: got no done expected done"); end
    checks++; if (cap_done !== 4'b0001) begin errors++; $display("FAIL write_done: got %b expected 0001", cap_done); end
    checks++; if (cap_err !== 1'b0) begin errors++; $display("FAIL write_err: got %b expected 0", cap_err); end
    checks++; if (cap_rdata !== 8'h00) begin errors++; $display("FAIL write_rdata: got %h expected 00", cap_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_at_done: got %b expected 0", busy); end
    checks++; if (bc0 + bc !== 11) begin errors++; $display("FAIL write_latency: got %0d expected 11", bc0 + bc); end
    checks++; if (log_op.size() !== 5) begin errors++; $display("FAIL write_cmd_count: got %0d expected 5", log_op.size()); end
    for (int i = 0; i < 5 && i < log_op.size(); i++) begin
      checks++; if (log_op[i] !== eo[i]) begin errors++; $display("FAIL write_op[%0d]: got %0d expected %0d", i, log_op[i], eo[i]); end
      if (eo[i] == OP_WRITE) begin
        checks++; if (log_data[i] !== ed[i]) begin errors++; $display("FAIL write_data[%0d]: got %h expected %h", i, log_data[i], ed[i]); end
      end
    end
    @(negedge clk_50);
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL write_done_pulse: got %b expected 0000", done); end
  endtask

  task automatic test_read();
    logic ok;
    int bc;
    logic [2:0] eo[7] = '{OP_START, OP_WRITE, OP_WRITE, OP_RSTART, OP_WRITE, OP_READ, OP_STOP};
    logic [7:0] ed[7] = '{8'h00, 8'hD0, 8'h38, 8'h00, 8'hD1, 8'h01, 8'h00};
    clear_log();
    read_byte = 8'hA5;
    set_req(2, 1'b1, 7'h68, 8'h38, 8'h00);
    req[2] = 1'b1;
    wait_done(100, ok, bc);
    req[2] = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL read_timeout: got no done expected done"); end
    checks++; if (cap_done !== 4'b0100) begin errors++; $display("FAIL read_done: got %b expected 0100", cap_done); end
    checks++; if (cap_err !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", cap_err); end
    checks++; if (cap_rdata !== 8'hA5) begin errors++; $display("FAIL read_rdata: got %h expected a5", cap_rdata); end
    checks++; if (log_op.size() !== 7) begin errors++; $display("FAIL read_cmd_count: got %0d expected 7", log_op.size()); end
    for (int i = 0; i < 7 && i < log_op.size(); i++) begin
      checks++; if (log_op[i] !== eo[i]) begin errors++; $display("FAIL read_op[%0d]: got %0d expected %0d", i, log_op[i], eo[i]); end
      if (eo[i] == OP_WRITE || eo[i] == OP_READ) begin
        checks++; if (log_data[i] !== ed[i]) begin errors++; $display("FAIL read_data[%0d]: got %h expected %h", i, log_data[i], ed[i]); end
      end
    end
    @(negedge clk_50);
  endtask

  task automatic test_nack();
    logic ok;
    int bc;
    clear_log();
    nack_en = 1'b1;
    nack_byte = 8'hD0;
    read_byte = 8'h5A;
    set_req(1, 1'b1, 7'h68, 8'h38, 8'h00);
    req[1] = 1'b1;
    wait_done(100, ok, bc);
    req[1] = 1'b0;
    nack_en = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nack_timeout: got no done expected done"); end
    checks++; if (cap_done !== 4'b0010) begin errors++; $display("FAIL nack_done: got %b expected 0010", cap_done); end
    checks++; if (cap_err !== 1'b1) begin errors++; $display("FAIL nack_err: got %b expected 1", cap_err); end
    checks++; if (cap_rdata !== 8'h00) begin errors++; $display("FAIL nack_rdata: got %h expected 00", cap_rdata); end
    checks++; if (log_op.size() !== 3) begin errors++; $display("FAIL nack_cmd_count: got %0d expected 3", log_op.size()); end
    if (log_op.size() >= 3) begin
      checks++; if (log_op[2] !== OP_STOP) begin errors++; $display("FAIL nack_stop_op: got %0d expected %0d", log_op[2], OP_STOP); end
    end
    @(negedge clk_50);
  endtask

  task automatic test_reset_mid();
    logic hs;
    int seen;
    set_req(3, 1'b0, 7'h50, 8'h01, 8'h02);
    req[3] = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk_50);
      hs = eng_cmd_valid && eng_cmd_ready;
    end
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL rstmid_handshake: got no command expected one"); end
    @(posedge clk_50);
    #1 state_reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (eng_cmd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_cmd_valid: got %b expected 0", eng_cmd_valid); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL rstmid_done: got %b expected 0000", done); end
    req[3] = 1'b0;
    repeat (3) @(negedge clk_50);
    state_reset = 1'b1;
    seen = 0;
    repeat (10) begin @(negedge clk_50); if (|done) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic ok;
    int bc, gi;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 7'(7'h10 + i), 8'(8'h40 + i), 8'(8'h80 + i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        repeat (3) @(negedge clk_50);
        req[1] = 1'b0;
      end
      wait_done(100, ok, bc);
      if (k == 4) req = 4'b0000;
      gi = -1;
      for (int j = 0; j < N; j++) if (cap_done[j]) gi = j;
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_timeout[%0d]: got no done expected done", k); end
      checks++; if (!$onehot(cap_done) || gi !== exp_g[k]) begin
        errors++; $display("FAIL rr_grant[%0d]: got done=%b expected requester %0d", k, cap_done, exp_g[k]);
      end
      checks++; if (cap_err !== 1'b0) begin errors++; $display("FAIL rr_err[%0d]: got %b expected 0", k, cap_err); end
      @(negedge clk_50);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_gap[%0d]: got busy=%b expected 0", k, busy); end
    end
    repeat (3) @(negedge clk_50);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got busy=%b expected 0", busy); end
  endtask

`ifdef I2C_TXN_TIMEOUT_EN
  task automatic test_timeout();
    logic ok;
    int bc;
    clear_log();
    silent = 1'b1;
    set_req(0, 1'b0, 7'h68, 8'h38, 8'hF0);
    req[0] = 1'b1;
    wait_done(200, ok, bc);
    req[0] = 1'b0;
    silent = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_no_done: got no done expected done"); end
    checks++; if (cap_done !== 4'b0001) begin errors++; $display("FAIL tmo_done: got %b expected 0001", cap_done); end
    checks++; if (cap_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", cap_err); end
    checks++; if (cap_rdata !== 8'h00) begin errors++; $display("FAIL tmo_rdata: got %h expected 00", cap_rdata); end
    checks++; if (log_op.size() !== 2) begin errors++; $display("FAIL tmo_cmd_count: got %0d expected 2", log_op.size()); end
    if (log_op.size() >= 2) begin
      checks++; if (log_op[1] !== OP_STOP) begin errors++; $display("FAIL tmo_stop_op: got %0d expected %0d", log_op[1], OP_STOP); end
      checks++; if (log_cyc[1] - log_cyc[0] !== 16) begin
        errors++; $display("FAIL tmo_stop_delay: got %0d cycles expected 16", log_cyc[1] - log_cyc[0]);
      end
    end
    @(negedge clk_50);
  endtask
`endif

  initial begin
    state_reset   = 1'b0;
    req           = '0;
    req_rnw       = '0;
    req_dev       = '0;
    req_reg       = '0;
    req_wdata     = '0;
    eng_cmd_ready = 1'b1;
    eng_rsp_valid = 1'b0;
    eng_rsp_nack  = 1'b0;
    eng_rsp_data  = 8'h00;
    silent        = 1'b0;
    nack_en       = 1'b0;
    nack_byte     = 8'h00;
    read_byte     = 8'h00;
    pending       = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_reset_mid();
    test_back_to_back();
`ifdef I2C_TXN_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "watchdog expired");
  end

endmodule
